// File: rtl/multiplier_if.sv
// Start/interrupt/ready/exception handshake shared with the divider.
// MULT_HI_EN adds the upper product half (result_hi).
interface multiplier_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic             start;
    logic             interrupt;
    logic [WIDTH-1:0] result;
    logic             ready;
    logic             busy;
    logic             exception;
`ifdef MULT_HI_EN
    logic [WIDTH-1:0] result_hi;
`endif

    modport master (
        output operandA, operandB, start, interrupt,
`ifdef MULT_HI_EN
        input  result_hi,
`endif
        input  result, ready, busy, exception
    );

    modport slave (
        input  operandA, operandB, start, interrupt,
`ifdef MULT_HI_EN
        output result_hi,
`endif
        output result, ready, busy, exception
    );
endinterface

// File: rtl/multiplier.sv
// Radix-2 Booth sequential signed multiplier, WIDTH cycles per operation.
// MULT_HI_EN exposes the upper product half as result_hi.
module multiplier #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic reset_n,
    multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH:0]   hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             q_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             exc_q;
    logic             ready_q;
    logic             busy_q;
    logic [WIDTH-1:0] res_hi_q;

    logic [WIDTH:0]   msext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   hi_d;
    logic [WIDTH-1:0] lo_d;
    logic             q_d;
    logic             last;
    logic             ovf;

    // hi is one bit wider than M so subtracting -2^(WIDTH-1) cannot wrap
    always_comb begin
        msext = {m_q[WIDTH-1], m_q};
        sum   = hi_q;
        unique case ({lo_q[0], q_q})
            2'b01:   sum = hi_q + msext;
            2'b10:   sum = hi_q - msext;
            default: sum = hi_q;
        endcase
        hi_d = {sum[WIDTH], sum[WIDTH:1]};
        lo_d = {sum[0], lo_q[WIDTH-1:1]};
        q_d  = lo_q[0];
        last = (cnt_q == CW'(WIDTH - 1));
        ovf  = (hi_d[WIDTH-1:0] != {WIDTH{lo_d[WIDTH-1]}});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            m_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            q_q      <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            res_hi_q <= '0;
        end else if (bus.start) begin
            state_q <= BUSY;
            m_q     <= bus.operandA;
            hi_q    <= '0;
            lo_q    <= bus.operandB;
            q_q     <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            unique case (state_q)
                BUSY: begin
                    if (bus.interrupt) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        hi_q  <= hi_d;
                        lo_q  <= lo_d;
                        q_q   <= q_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (last) begin
                            result_q <= lo_d;
                            res_hi_q <= hi_d[WIDTH-1:0];
                            exc_q    <= ovf;
                            ready_q  <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.interrupt) begin
                        state_q <= IDLE;
                        ready_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result    = result_q;
    assign bus.ready     = ready_q;
    assign bus.busy      = busy_q;
    assign bus.exception = exc_q;
`ifdef MULT_HI_EN
    assign bus.result_hi = res_hi_q;
`else
    logic unused_hi;
    assign unused_hi = ^res_hi_q;
`endif
endmodule

// File: tb/tb_multiplier.sv
// Directed bench for the Booth multiplier: latency, overflow,
// interrupt, restart and asynchronous reset.
module tb_multiplier;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   pass_cnt = 0;
    int   total = 0;

    multiplier_if #(.WIDTH(W)) bus ();

    multiplier #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // caller sits at a negedge; the next posedge is the start edge
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.operandA = a;
        bus.operandB = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // cycles from the start edge until ready is seen; 41 on timeout
    task automatic wait_ready(output int n);
        n = 0;
        while (n <= 40 && bus.ready !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        if (bus.ready !== 1'b1) n = 41;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.result !== '0) $display("FAIL reset_result got %h want 0", bus.result);
        else pass_cnt++;
        total++;
        if (bus.ready !== 1'b0) $display("FAIL reset_ready got %b want 0", bus.ready);
        else pass_cnt++;
        total++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy);
        else pass_cnt++;
        total++;
        if (bus.exception !== 1'b0) $display("FAIL reset_exc got %b want 0", bus.exception);
        else pass_cnt++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int n;
        start_op(32'd7, 32'hFFFF_FFFD);
        total++;
        if (bus.busy !== 1'b1) $display("FAIL basic_busy_on got %b want 1", bus.busy);
        else pass_cnt++;
        wait_ready(n);
        total++;
        if (n != 32) $display("FAIL basic_latency got %0d want 32", n);
        else pass_cnt++;
        total++;
        if (bus.result !== 32'hFFFF_FFEB) $display("FAIL basic_result got %h want ffffffeb", bus.result);
        else pass_cnt++;
        total++;
        if (bus.exception !== 1'b0) $display("FAIL basic_exc got %b want 0", bus.exception);
        else pass_cnt++;
        total++;
        if (bus.busy !== 1'b0) $display("FAIL basic_busy_off got %b want 0", bus.busy);
        else pass_cnt++;
`ifdef MULT_HI_EN
        total++;
        if (bus.result_hi !== 32'hFFFF_FFFF) $display("FAIL basic_hi got %h want ffffffff", bus.result_hi);
        else pass_cnt++;
`endif
        repeat (3) @(negedge clk);
        total++;
        if (bus.ready !== 1'b1 || bus.result !== 32'hFFFF_FFEB)
            $display("FAIL basic_hold got rdy=%b res=%h want rdy=1 res=ffffffeb", bus.ready, bus.result);
        else pass_cnt++;
    endtask

    task automatic test_overflow;
        logic [W-1:0] va [5] = '{32'h8000_0000, 32'h8000_0000, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0};
        logic [W-1:0] vb [5] = '{32'hFFFF_FFFF, 32'h1, 32'h0001_0000, 32'hFFFF_FFFF, 32'h5};
        logic [W-1:0] vr [5] = '{32'h8000_0000, 32'h8000_0000, 32'h0, 32'h1, 32'h0};
        logic         ve [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] vh [5] = '{32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0};
        int n;
        for (int i = 0; i < 5; i++) begin
            start_op(va[i], vb[i]);
            wait_ready(n);
            total++;
            if (n != 32) $display("FAIL ovf%0d_latency got %0d want 32", i, n);
            else pass_cnt++;
            total++;
            if (bus.result !== vr[i]) $display("FAIL ovf%0d_result got %h want %h", i, bus.result, vr[i]);
            else pass_cnt++;
            total++;
            if (bus.exception !== ve[i]) $display("FAIL ovf%0d_exc got %b want %b", i, bus.exception, ve[i]);
            else pass_cnt++;
`ifdef MULT_HI_EN
            total++;
            if (bus.result_hi !== vh[i]) $display("FAIL ovf%0d_hi got %h want %h", i, bus.result_hi, vh[i]);
            else pass_cnt++;
`else
            if (vh[i] === 'x) $display("unreachable");
`endif
        end
    endtask

    task automatic test_interrupt;
        int n;
        start_op(32'd7, 32'hFFFF_FFFD);
        wait_ready(n);
        start_op(32'd5, 32'd6);
        repeat (9) @(negedge clk);
        bus.interrupt = 1'b1;
        @(negedge clk);
        bus.interrupt = 1'b0;
        total++;
        if (bus.busy !== 1'b0) $display("FAIL irq_busy got %b want 0", bus.busy);
        else pass_cnt++;
        wait_ready(n);
        total++;
        if (n != 41) $display("FAIL irq_no_ready got ready after %0d cycles want none", n);
        else pass_cnt++;
        total++;
        if (bus.result !== 32'hFFFF_FFEB) $display("FAIL irq_result_held got %h want ffffffeb", bus.result);
        else pass_cnt++;
        start_op(32'd5, 32'd6);
        wait_ready(n);
        total++;
        if (n != 32 || bus.result !== 32'd30)
            $display("FAIL irq_rerun got n=%0d res=%h want n=32 res=1e", n, bus.result);
        else pass_cnt++;
        bus.interrupt = 1'b1;
        @(negedge clk);
        bus.interrupt = 1'b0;
        total++;
        if (bus.ready !== 1'b0 || bus.result !== 32'd30)
            $display("FAIL irq_done got rdy=%b res=%h want rdy=0 res=1e", bus.ready, bus.result);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int n;
        start_op(32'd3, 32'd4);
        repeat (4) @(negedge clk);
        start_op(32'hFFFF_FFF8, 32'd9);
        wait_ready(n);
        total++;
        if (n != 32) $display("FAIL restart_latency got %0d want 32", n);
        else pass_cnt++;
        total++;
        if (bus.result !== 32'hFFFF_FFB8) $display("FAIL restart_result got %h want ffffffb8", bus.result);
        else pass_cnt++;
    endtask

    task automatic test_async_reset;
        int n;
        start_op(32'h0001_0000, 32'h0001_0000);
        wait_ready(n);
        start_op(32'd7, 32'd9);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (bus.result !== '0 || bus.ready !== 1'b0 || bus.busy !== 1'b0 || bus.exception !== 1'b0)
            $display("FAIL async_reset got res=%h rdy=%b busy=%b exc=%b want all 0",
                     bus.result, bus.ready, bus.busy, bus.exception);
        else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        start_op(32'd2, 32'd2);
        wait_ready(n);
        total++;
        if (n != 32 || bus.result !== 32'd4)
            $display("FAIL post_reset got n=%0d res=%h want n=32 res=4", n, bus.result);
        else pass_cnt++;
    endtask

    initial begin
        bus.operandA = '0;
        bus.operandB = '0;
        bus.start = 1'b0;
        bus.interrupt = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_interrupt();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
